nibble_serial_add_ctrl: RTL and testbench
=========================================

// Module: nibble_serial_add_ctrl
// PURPOSE
//  Sequencer that computes wide add/subtract on one shared external 4-bit ripple adder
//  slice, processing one nibble per cycle from LSB to MSB.
//  Sits between a requester (valid/ready start handshake) and the combinational
//  4-bit adder datapath. Drives the adder inputs, chains the carry and assembles the result.
// PARAMETERS
//  NIBBLES  4  operand width in nibbles; W = 4*NIBBLES bits (NIBBLES >= 1)
// PORTS
//  clk          in   1    single clock, rising edge
//  rst_n        in   1    asynchronous, active-low reset
//  start_valid  in   1    request present
//  start_ready  out  1    block can accept a request (IDLE)
//  op_a         in   W    operand A, sampled at handshake
//  op_b         in   W    operand B, sampled at handshake
//  cin          in   1    carry in (add mode only)
//  sub          in   1    1 = A - B (A + ~B + 1, cin ignored)
//  add_x        out  4    to adder slice, A nibble
//  add_y        out  4    to adder slice, B nibble (inverted when sub)
//  add_cin      out  1    to adder slice, carry in
//  add_s        in   4    from adder slice, sum nibble (combinational)
//  add_cout     in   1    from adder slice, carry out
//  busy         out  1    state != IDLE
//  done_valid   out  1    result available (DONE)
//  done_ready   in   1    consumer takes result
//  result       out  W    sum/difference
//  cout         out  1    final carry (sub: 1 = no borrow)
//  overflow     out  1    two's-complement overflow
// BEHAVIOUR
//  - FSM states: IDLE, RUN, DONE. Nibble index idx is a counter from 0 to NIBBLES-1.
//    The carry register is carry.
//  - Reset (async, rst_n=0): state=IDLE, idx=0, carry=0, result=0, cout=0, overflow=0,
//    done_valid=0, busy=0. start_ready=1 once rst_n deasserts.
//  - IDLE: start_ready=1. On start_valid&start_ready at an edge:
//    a_reg=op_a; b_reg = sub ? ~op_b : op_b; carry = sub ? 1 : cin; idx=0; go to RUN.
//  - RUN: add_x=a_reg[4*idx+:4], add_y=b_reg[4*idx+:4], add_cin=carry.
//    Each edge: result[4*idx+:4]=add_s; carry=add_cout.
//    If idx==NIBBLES-1, go to DONE; otherwise idx=idx+1.
//  - On the DONE entry edge: cout=add_cout.
//    overflow = (a_reg[W-1]==b_reg[W-1]) & (add_s[3]!=a_reg[W-1]).
//  - DONE: done_valid=1; result/cout/overflow held stable. On done_ready, go to IDLE.
//    Outputs stay valid until the next request overwrites them.
//  - add_x/add_y/add_cin are 0 outside RUN.
//  - Latency: done_valid rises exactly NIBBLES cycles after the accepting edge.
//    Minimum request spacing is NIBBLES+2 cycles.
//  - start_valid in RUN/DONE is ignored (start_ready=0). Op inputs may change freely after
//    the handshake.
//  - done_ready outside DONE is ignored. done_ready held high means DONE lasts exactly 1 cycle.
//  - Carry-out of the top nibble wraps out via cout only. result is never wider than W.
//  - rst_n asserted mid-RUN or mid-DONE: abort immediately, no done_valid pulse,
//    outputs take reset values.
// TESTING (NIBBLES=4)
//  1. add 0x1234+0x0FFF, cin=0 -> result=0x2233, cout=0, overflow=0; done_valid 4 cycles after accept
//  2. add 0xFFFF+0x0001, cin=0 -> result=0x0000, cout=1, overflow=0; add_cin per nibble = 0,1,1,1
//  3. add 0x7FFF+0x0001 -> result=0x8000, cout=0, overflow=1
//  4. sub 0x0005-0x0007 -> result=0xFFFE, cout=0, overflow=0; sub 0x8000-0x0001 -> 0x7FFF, overflow=1
//  5. hold done_ready=0 for 10 cycles with start_valid=1 -> result stable, start_ready=0,
//     no new accept; release -> IDLE, next op accepted
//  6. rst_n low during RUN at idx=2 -> immediate IDLE, result=0, done_valid never asserted;
//     next op completes correctly

Source files
------------

// File: rtl/nibble_serial_add_ctrl.sv
// rtl/nibble_serial_add_ctrl.sv - wide add/subtract sequenced over a shared 4-bit adder slice
// One nibble per cycle, LSB first; the external slice is purely combinational.
module nibble_serial_add_ctrl #(
  parameter int NIBBLES = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start_valid,
  output logic                 start_ready,
  input  logic [4*NIBBLES-1:0] op_a,
  input  logic [4*NIBBLES-1:0] op_b,
  input  logic                 cin,
  input  logic                 sub,
  output logic [3:0]           add_x,
  output logic [3:0]           add_y,
  output logic                 add_cin,
  input  logic [3:0]           add_s,
  input  logic                 add_cout,
  output logic                 busy,
  output logic                 done_valid,
  input  logic                 done_ready,
  output logic [4*NIBBLES-1:0] result,
  output logic                 cout,
  output logic                 overflow
);

  localparam int W    = 4 * NIBBLES;
  localparam int IDXW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [IDXW-1:0] LAST = IDXW'(NIBBLES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state;
  state_t          state_n;
  logic [IDXW-1:0] idx;
  logic            carry;
  logic [W-1:0]    a_reg;
  logic [W-1:0]    b_reg;
  logic            last_nib;

  assign last_nib = (idx == LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  always_comb begin
    state_n     = state;
    start_ready = 1'b0;
    busy        = 1'b1;
    done_valid  = 1'b0;
    add_x       = 4'h0;
    add_y       = 4'h0;
    add_cin     = 1'b0;
    case (state)
      IDLE: begin
        start_ready = 1'b1;
        busy        = 1'b0;
        if (start_valid) state_n = RUN;
      end
      RUN: begin
        add_x   = a_reg[{idx, 2'b00} +: 4];
        add_y   = b_reg[{idx, 2'b00} +: 4];
        add_cin = carry;
        if (last_nib) state_n = DONE;
      end
      DONE: begin
        done_valid = 1'b1;
        if (done_ready) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // Subtraction is folded into the operand capture: B is stored inverted and the carry seeded with 1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx      <= '0;
      carry    <= 1'b0;
      a_reg    <= '0;
      b_reg    <= '0;
      result   <= '0;
      cout     <= 1'b0;
      overflow <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start_valid) begin
            a_reg <= op_a;
            b_reg <= sub ? ~op_b : op_b;
            carry <= sub ? 1'b1 : cin;
            idx   <= '0;
          end
        end
        RUN: begin
          result[{idx, 2'b00} +: 4] <= add_s;
          carry                     <= add_cout;
          if (last_nib) begin
            cout     <= add_cout;
            overflow <= (a_reg[W-1] == b_reg[W-1]) & (add_s[3] != a_reg[W-1]);
          end else begin
            idx <= idx + 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_nibble_serial_add_ctrl.sv
// tb/tb_nibble_serial_add_ctrl.sv - self-checking bench for nibble_serial_add_ctrl
// Models the external adder slice and scoreboards results against a whole-word model.
module tb_nibble_serial_add_ctrl;

  localparam int N = 4;
  localparam int W = 4 * N;

  typedef struct {
    logic [W-1:0] r;
    logic         c;
    logic         ov;
  } exp_t;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         ci;
    logic         s;
    logic [W-1:0] r;
    logic         c;
    logic         ov;
  } vec_t;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start_valid = 1'b0;
  logic         start_ready;
  logic [W-1:0] op_a = '0;
  logic [W-1:0] op_b = '0;
  logic         cin = 1'b0;
  logic         sub = 1'b0;
  logic [3:0]   add_x;
  logic [3:0]   add_y;
  logic         add_cin;
  logic [3:0]   add_s;
  logic         add_cout;
  logic         busy;
  logic         done_valid;
  logic         done_ready = 1'b0;
  logic [W-1:0] result;
  logic         cout;
  logic         overflow;
  logic [4:0]   slice;

  int   n_checks = 0;
  int   n_fail = 0;
  exp_t sb[$];
  vec_t vecs[8];

  assign slice = {1'b0, add_x} + {1'b0, add_y} + {4'b0, add_cin};
  assign add_s = slice[3:0];
  assign add_cout = slice[4];

  nibble_serial_add_ctrl #(.NIBBLES(N)) dut (
    .clk(clk), .rst_n(rst_n),
    .start_valid(start_valid), .start_ready(start_ready),
    .op_a(op_a), .op_b(op_b), .cin(cin), .sub(sub),
    .add_x(add_x), .add_y(add_y), .add_cin(add_cin),
    .add_s(add_s), .add_cout(add_cout),
    .busy(busy), .done_valid(done_valid), .done_ready(done_ready),
    .result(result), .cout(cout), .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic exp_t model(input logic [W-1:0] a, b, input logic ci, s);
    exp_t         e;
    logic [W-1:0] bb;
    logic [W:0]   full;
    bb   = s ? ~b : b;
    full = {1'b0, a} + {1'b0, bb} + {{W{1'b0}}, (s ? 1'b1 : ci)};
    e.r  = full[W-1:0];
    e.c  = full[W];
    e.ov = (a[W-1] == bb[W-1]) && (full[W-1] != a[W-1]);
    return e;
  endfunction

  function automatic logic [N-1:0] cin_model(input logic [W-1:0] a, b, input logic ci, s);
    logic [N-1:0] cs;
    logic [W-1:0] bb;
    logic         c;
    logic [4:0]   t;
    bb = s ? ~b : b;
    c  = s ? 1'b1 : ci;
    for (int i = 0; i < N; i++) begin
      cs[i] = c;
      t = {1'b0, a[4*i +: 4]} + {1'b0, bb[4*i +: 4]} + {4'b0, c};
      c = t[4];
    end
    return cs;
  endfunction

  // Returns at the falling edge right after the accepting edge (DUT in RUN, idx=0).
  task automatic issue(input logic [W-1:0] a, b, input logic ci, s, input exp_t e);
    int w = 0;
    @(negedge clk);
    while (!start_ready && w < 100) begin
      @(negedge clk);
      w++;
    end
    check("start_ready_before_issue", start_ready, 1);
    op_a = a; op_b = b; cin = ci; sub = s; start_valid = 1'b1;
    @(posedge clk);
    sb.push_back(e);
    @(negedge clk);
    start_valid = 1'b0;
    op_a = W'($urandom); op_b = W'($urandom); cin = 1'($urandom); sub = 1'($urandom);
  endtask

  task automatic finish_op(input string tag, input logic [N-1:0] exp_cins, input logic release_it);
    int           lat = 0;
    logic [N-1:0] cins = '0;
    exp_t         e;
    while (!done_valid && lat < 50) begin
      if (lat < N) cins[lat] = add_cin;
      @(negedge clk);
      lat++;
    end
    check({tag, "_latency"}, lat, N);
    check({tag, "_add_cin_seq"}, 32'(cins), 32'(exp_cins));
    if (sb.size() == 0) begin
      check({tag, "_scoreboard_nonempty"}, 0, 1);
    end else begin
      e = sb.pop_front();
      check({tag, "_result"}, 32'(result), 32'(e.r));
      check({tag, "_cout"}, 32'(cout), 32'(e.c));
      check({tag, "_overflow"}, 32'(overflow), 32'(e.ov));
    end
    if (release_it) begin
      done_ready = 1'b1;
      @(negedge clk);
      done_ready = 1'b0;
      check({tag, "_idle_after_release"}, 32'(busy), 0);
    end
  endtask

  task automatic run_vec(input string tag, input vec_t v);
    exp_t e;
    e.r = v.r; e.c = v.c; e.ov = v.ov;
    issue(v.a, v.b, v.ci, v.s, e);
    finish_op(tag, cin_model(v.a, v.b, v.ci, v.s), 1'b1);
  endtask

  initial begin
    logic [W-1:0] snap;
    logic [W-1:0] ra, rb;
    logic         rc, rs;
    int           seen_done;

    vecs[0] = '{16'h1234, 16'h0FFF, 1'b0, 1'b0, 16'h2233, 1'b0, 1'b0};
    vecs[1] = '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0};
    vecs[2] = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1};
    vecs[3] = '{16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0};
    vecs[4] = '{16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1};
    vecs[5] = '{16'h00FF, 16'h0000, 1'b1, 1'b0, 16'h0100, 1'b0, 1'b0};
    vecs[6] = '{16'h1234, 16'h1234, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0};
    vecs[7] = '{16'h0010, 16'h0001, 1'b1, 1'b1, 16'h000F, 1'b1, 1'b0};

    #1;
    check("reset_busy", 32'(busy), 0);
    check("reset_done_valid", 32'(done_valid), 0);
    check("reset_result", 32'(result), 0);
    check("reset_cout_ovf", 32'({cout, overflow}), 0);
    check("reset_adder_inputs", 32'({add_x, add_y, add_cin}), 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("start_ready_after_reset", 32'(start_ready), 1);

    foreach (vecs[i]) run_vec($sformatf("vec%0d", i), vecs[i]);

    // Carry into each nibble for 0xFFFF+0x0001 must be 0,1,1,1 (bit i = nibble i).
    check("ffff_plus_1_cin_model", 32'(cin_model(16'hFFFF, 16'h0001, 1'b0, 1'b0)), 32'(4'b1110));

    for (int k = 0; k < 6; k++) begin
      ra = W'($urandom); rb = W'($urandom); rc = 1'($urandom); rs = 1'($urandom);
      issue(ra, rb, rc, rs, model(ra, rb, rc, rs));
      finish_op($sformatf("rand%0d", k), cin_model(ra, rb, rc, rs), 1'b1);
    end

    // Consumer stall: result must hold and no new request may be taken.
    issue(16'h1234, 16'h0FFF, 1'b0, 1'b0, model(16'h1234, 16'h0FFF, 1'b0, 1'b0));
    finish_op("stall", cin_model(16'h1234, 16'h0FFF, 1'b0, 1'b0), 1'b0);
    snap = result;
    start_valid = 1'b1;
    for (int c = 0; c < 10; c++) begin
      op_a = W'($urandom); op_b = W'($urandom);
      @(negedge clk);
      check("stall_state", 32'({done_valid, start_ready}), 32'(2'b10));
      check("stall_result_stable", 32'(result), 32'(snap));
    end
    op_a = 16'h0F0F; op_b = 16'h0101; cin = 1'b0; sub = 1'b0;
    done_ready = 1'b1;
    @(negedge clk);
    done_ready = 1'b0;
    check("stall_release_idle", 32'({done_valid, start_ready}), 32'(2'b01));
    @(posedge clk);
    sb.push_back(model(16'h0F0F, 16'h0101, 1'b0, 1'b0));
    @(negedge clk);
    start_valid = 1'b0;
    finish_op("after_stall", cin_model(16'h0F0F, 16'h0101, 1'b0, 1'b0), 1'b1);

    // Reset asserted mid-RUN at idx=2.
    issue(16'hABCD, 16'h1111, 1'b0, 1'b0, model(16'hABCD, 16'h1111, 1'b0, 1'b0));
    @(negedge clk);
    @(negedge clk);
    check("midrun_add_x_idx2", 32'(add_x), 32'h0B);
    rst_n = 1'b0;
    #1;
    void'(sb.pop_back());
    check("midrun_reset_busy", 32'(busy), 0);
    check("midrun_reset_result", 32'(result), 0);
    seen_done = 0;
    for (int c = 0; c < 8; c++) begin
      if (c == 2) rst_n = 1'b1;
      @(negedge clk);
      if (done_valid) seen_done++;
    end
    check("midrun_no_done_pulse", seen_done, 0);
    check("midrun_idle_ready", 32'(start_ready), 1);
    run_vec("post_reset", vecs[4]);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
